// File: rtl/jt5205_seq_fetch.sv
// jt5205_seq_fetch: ROM request/ack handshake, byte address counter, last-byte tag and one-byte prefetch buffer
module jt5205_seq_fetch #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          load,
    input  logic          en,
    input  logic          direct,
    input  logic          take,
    input  logic          loop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    output logic          acc,
    output logic          last,
    output logic          looping,
    output logic [7:0]    nxt,
    output logic          nxt_last,
    output logic          nxt_valid
);
    logic [AW-1:0] first_q, end_q;
    logic          armed, more;
    // armed means rom_cs was already high last cycle, so an ok left over from before the request is ignored
    assign acc  = rom_cs & armed & rom_ok;
    assign last = rom_addr == end_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr  <= '0;
            rom_cs    <= 1'b0;
            armed     <= 1'b0;
            more      <= 1'b0;
            looping   <= 1'b0;
            first_q   <= '0;
            end_q     <= '0;
            nxt       <= '0;
            nxt_last  <= 1'b0;
            nxt_valid <= 1'b0;
        end else if (flush) begin
            rom_cs    <= 1'b0;
            armed     <= 1'b0;
            nxt_valid <= 1'b0;
            more      <= load;
            if (load) begin
                first_q  <= start_addr;
                end_q    <= end_addr;
                looping  <= loop;
                rom_addr <= start_addr;
            end
        end else begin
            armed <= rom_cs & ~acc;
            if (acc) begin
                rom_cs   <= 1'b0;
                rom_addr <= (last & looping) ? first_q : rom_addr + AW'(1);
                more     <= ~last | looping;
            end else if (en & more & ~nxt_valid & ~rom_cs) begin
                rom_cs <= 1'b1;
            end
            // a byte the player is waiting on bypasses the buffer
            if (acc & ~direct) begin
                nxt       <= rom_data;
                nxt_last  <= last;
                nxt_valid <= 1'b1;
            end else if (take) begin
                nxt_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/jt5205_seq.sv
// jt5205_seq: ADPCM sample player feeding jt5205 one nibble per irq from a start/end ROM range
module jt5205_seq #(
    parameter int AW       = 16,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          irq,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    din,
    output logic          adpcm_rst,
    output logic          busy,
    output logic          done,
    output logic          underrun
);
    localparam logic [1:0] IDLE = 2'd0, PRIME = 2'd1, PLAY = 2'd2;
    logic [1:0] state, state_nx;
    logic [7:0] cur, nxt, src;
    logic       cur_last, nib, starved, nxt_last, nxt_valid, acc, acc_last, looping;
    logic       step, fin, roll, need, have, take, direct, flush;

    function automatic logic [3:0] first_nib(input logic [7:0] b);
        return HI_FIRST ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [3:0] second_nib(input logic [7:0] b);
        return HI_FIRST ? b[3:0] : b[7:4];
    endfunction

    // step: irq consumed a real nibble; roll: a fresh byte is needed for the next nibble
    assign step   = (state == PLAY) & irq & ~starved;
    assign fin    = step & nib & cur_last & ~looping;
    assign roll   = starved | (step & nib & ~(cur_last & ~looping));
    assign need   = (state == PRIME) | roll;
    assign have   = nxt_valid | acc;
    assign take   = need & nxt_valid;
    assign direct = need & ~nxt_valid;
    assign src    = nxt_valid ? nxt : rom_data;
    assign flush  = start | stop | fin;

    jt5205_seq_fetch #(.AW(AW)) u_fetch (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (start & ~stop),
        .en         (state != IDLE),
        .direct     (direct),
        .take       (take),
        .loop       (loop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .rom_addr   (rom_addr),
        .rom_cs     (rom_cs),
        .acc        (acc),
        .last       (acc_last),
        .looping    (looping),
        .nxt        (nxt),
        .nxt_last   (nxt_last),
        .nxt_valid  (nxt_valid)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = stop ? IDLE : start ? PRIME : (state == PRIME && acc) ? PLAY : fin ? IDLE : state;
    end

    always_comb begin
        busy      = state != IDLE;
        adpcm_rst = state != PLAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= '0;
            cur_last <= 1'b0;
            nib      <= 1'b0;
            starved  <= 1'b0;
            din      <= '0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else if (flush) begin
            cur      <= '0;
            cur_last <= 1'b0;
            nib      <= 1'b0;
            starved  <= 1'b0;
            din      <= '0;
            done     <= fin & ~start & ~stop;
            underrun <= underrun & ~(start & ~stop);
        end else begin
            done <= 1'b0;
            if (need && have) begin
                cur      <= src;
                cur_last <= nxt_valid ? nxt_last : acc_last;
                nib      <= 1'b0;
                starved  <= 1'b0;
                din      <= first_nib(src);
            end else if (roll) begin
                starved <= 1'b1;
                din     <= '0;
            end else if (step) begin
                nib <= 1'b1;
                din <= second_nib(cur);
            end
            underrun <= underrun | (irq & roll & ~have);
        end
    end
endmodule
